// File: rtl/user_value_entry_pkg.sv
// Shared constants for the user value entry block: FSM encodings, value width,
// default 50 MHz timing constants and key indices.
package user_value_entry_pkg;

    localparam int USER_VALUE_W = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EDIT   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_TIMEOUT_CYCLES  = 250000000;
    localparam int DEF_HOLD_CYCLES     = 50000000;
    localparam int DEF_REPEAT_CYCLES   = 12500000;

    localparam int KEY_NEXT  = 0;
    localparam int KEY_ENTER = 1;
    localparam int NUM_KEYS  = 2;

    typedef logic [USER_VALUE_W-1:0] user_value_t;

    // Values wrap 3 -> 0.
    function automatic user_value_t next_value(input user_value_t v);
        return v + user_value_t'(1);
    endfunction

endpackage

// File: rtl/user_value_entry_key_debounce.sv
// Conditions one raw active-low key: 2-FF synchronizer, consecutive-cycle
// debounce, and a one-cycle press pulse on the released->pressed flip.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pressed,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_n_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             press_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg   <= 1'b1;
            sync2_reg   <= 1'b1;
            level_n_reg <= 1'b1;
            cnt_reg     <= '0;
            press_reg   <= 1'b0;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (sync2_reg == level_n_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_n_reg <= sync2_reg;
                cnt_reg     <= '0;
                press_reg   <= ~sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign pressed = ~level_n_reg;
    assign press   = press_reg;

endmodule

// File: rtl/user_value_entry.sv
// Debounced NEXT/ENTER edit-and-commit of a 2-bit user value.
// Optional NEXT auto-repeat is enabled by defining USER_VALUE_AUTO_REPEAT_EN.
module user_value_entry
    import user_value_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_next_n,
    input  logic                    key_enter_n,
    output logic [USER_VALUE_W-1:0] user,
    output logic [USER_VALUE_W-1:0] candidate,
    output logic                    editing,
    output logic                    commit
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [NUM_KEYS-1:0] keys_n;
    logic [NUM_KEYS-1:0] pressed_vec;
    logic [NUM_KEYS-1:0] press_vec;

    assign keys_n = {key_enter_n, key_next_n};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .rst    (rst),
                .key_n  (keys_n[gi]),
                .pressed(pressed_vec[gi]),
                .press  (press_vec[gi])
            );
        end
    endgenerate

    logic [1:0]        state_reg;
    user_value_t       user_reg;
    user_value_t       cand_reg;
    logic              editing_reg;
    logic              commit_reg;
    logic [TO_W-1:0]   timeout_reg;

    logic next_ev;
    logic enter_ev;
    logic step_ev;
    logic unused_levels;

    assign next_ev       = press_vec[KEY_NEXT];
    assign enter_ev      = press_vec[KEY_ENTER];
    assign unused_levels = ^pressed_vec;

`ifdef USER_VALUE_AUTO_REPEAT_EN
    localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] hold_reg;
    logic             repeating_reg;
    logic             next_held;
    logic             repeat_ev;

    assign next_held = pressed_vec[KEY_NEXT];
    assign repeat_ev = (state_reg == ST_EDIT) && next_held && !next_ev &&
                       (repeating_reg ? (hold_reg == RPT_W'(REPEAT_CYCLES - 1))
                                      : (hold_reg == RPT_W'(HOLD_CYCLES - 1)));
    assign step_ev   = next_ev | repeat_ev;

    // Hold timing restarts at every genuine press; first gap is HOLD, then REPEAT.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_reg      <= '0;
            repeating_reg <= 1'b0;
        end else if (next_ev || !next_held || state_reg != ST_EDIT) begin
            hold_reg      <= '0;
            repeating_reg <= 1'b0;
        end else if (repeat_ev) begin
            hold_reg      <= '0;
            repeating_reg <= 1'b1;
        end else begin
            hold_reg <= hold_reg + RPT_W'(1);
        end
    end
`else
    localparam int unused_repeat_cfg = HOLD_CYCLES + REPEAT_CYCLES;
    assign step_ev = next_ev;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            user_reg    <= '0;
            cand_reg    <= '0;
            editing_reg <= 1'b0;
            commit_reg  <= 1'b0;
            timeout_reg <= '0;
        end else begin
            commit_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    cand_reg <= user_reg;
                    if (next_ev) begin
                        state_reg   <= ST_EDIT;
                        cand_reg    <= next_value(user_reg);
                        editing_reg <= 1'b1;
                        timeout_reg <= '0;
                    end
                end
                ST_EDIT: begin
                    // ENTER has priority over a simultaneous NEXT or repeat.
                    if (enter_ev) begin
                        state_reg   <= ST_COMMIT;
                        user_reg    <= cand_reg;
                        editing_reg <= 1'b0;
                        commit_reg  <= 1'b1;
                    end else if (step_ev) begin
                        cand_reg    <= next_value(cand_reg);
                        timeout_reg <= '0;
                    end else if (timeout_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_reg   <= ST_IDLE;
                        cand_reg    <= user_reg;
                        editing_reg <= 1'b0;
                        timeout_reg <= '0;
                    end else begin
                        timeout_reg <= timeout_reg + TO_W'(1);
                    end
                end
                ST_COMMIT: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    cand_reg    <= user_reg;
                    editing_reg <= 1'b0;
                end
            endcase
        end
    end

    assign user      = user_reg;
    assign candidate = cand_reg;
    assign editing   = editing_reg;
    assign commit    = commit_reg;

endmodule

// File: tb/tb_user_value_entry.sv
// Self-checking bench for user_value_entry: directed timing scenarios plus a
// randomized key sequence checked against an abstract edit/commit model.
module tb_user_value_entry;

    localparam int D  = 4;
    localparam int T  = 20;
    localparam int H  = 10;
    localparam int R  = 3;
    localparam int LAT = D + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_next_n = 1'b1;
    logic       key_enter_n = 1'b1;
    logic [1:0] user;
    logic [1:0] candidate;
    logic       editing;
    logic       commit;

    int compared = 0;
    int mismatched = 0;
    int commit_cnt = 0;
    int m_user = 0;
    int m_cand = 0;
    int m_edit = 0;

    user_value_entry #(
        .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES (T),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_next_n (key_next_n),
        .key_enter_n(key_enter_n),
        .user       (user),
        .candidate  (candidate),
        .editing    (editing),
        .commit     (commit)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (commit === 1'b1) commit_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_next(input int low, input int high);
        key_next_n = 1'b0;
        tick(low);
        key_next_n = 1'b1;
        tick(high);
    endtask

    task automatic press_enter(input int low, input int high);
        key_enter_n = 1'b0;
        tick(low);
        key_enter_n = 1'b1;
        tick(high);
    endtask

    task automatic test_reset;
        int c0;
        rst = 1'b1;
        key_next_n = 1'b1;
        key_enter_n = 1'b1;
        tick(3);
        compared++;
        if (user !== 2'd0 || candidate !== 2'd0 || editing !== 1'b0 || commit !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got user=%0d cand=%0d edit=%0d commit=%0d want 0/0/0/0",
                     user, candidate, editing, commit);
        end
        rst = 1'b0;
        c0 = commit_cnt;
        tick(10);
        compared++;
        if (user !== 2'd0 || candidate !== 2'd0 || editing !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_idle: got user=%0d cand=%0d edit=%0d want 0/0/0", user, candidate, editing);
        end
        compared++;
        if (commit_cnt !== c0) begin
            mismatched++;
            $display("FAIL reset_no_commit: got %0d commit cycles want 0", commit_cnt - c0);
        end
        m_user = 0; m_cand = 0; m_edit = 0;
    endtask

    task automatic test_first_commit;
        int c0;
        c0 = commit_cnt;
        key_next_n = 1'b0;
        tick(LAT - 1);
        compared++;
        if (candidate !== 2'd0 || editing !== 1'b0) begin
            mismatched++;
            $display("FAIL latency_early: got cand=%0d edit=%0d want 0/0 at edge %0d", candidate, editing, LAT - 1);
        end
        tick(1);
        compared++;
        if (candidate !== 2'd1 || editing !== 1'b1) begin
            mismatched++;
            $display("FAIL latency_edge: got cand=%0d edit=%0d want 1/1 at edge %0d", candidate, editing, LAT);
        end
        tick(1);
        key_next_n = 1'b1;
        key_enter_n = 1'b0;
        tick(LAT);
        compared++;
        if (commit !== 1'b1 || user !== 2'd1 || editing !== 1'b0) begin
            mismatched++;
            $display("FAIL commit_edge: got commit=%0d user=%0d edit=%0d want 1/1/0", commit, user, editing);
        end
        tick(1);
        compared++;
        if (commit !== 1'b0) begin
            mismatched++;
            $display("FAIL commit_width: got commit=%0d one cycle later want 0", commit);
        end
        key_enter_n = 1'b1;
        tick(10);
        compared++;
        if (commit_cnt - c0 !== 1 || user !== 2'd1 || candidate !== 2'd1 || editing !== 1'b0) begin
            mismatched++;
            $display("FAIL first_commit: got commits=%0d user=%0d cand=%0d edit=%0d want 1/1/1/0",
                     commit_cnt - c0, user, candidate, editing);
        end
        m_user = 1; m_cand = 1; m_edit = 0;
    endtask

    task automatic test_wrap;
        int c0;
        c0 = commit_cnt;
        for (int i = 0; i < 4; i++) begin
            press_next(8, 10);
            m_cand = (m_edit != 0) ? (m_cand + 1) % 4 : (m_user + 1) % 4;
            m_edit = 1;
            compared++;
            if (candidate !== 2'(m_cand) || editing !== 1'b1) begin
                mismatched++;
                $display("FAIL wrap_step%0d: got cand=%0d edit=%0d want %0d/1", i, candidate, editing, m_cand);
            end
        end
        press_enter(8, 10);
        m_user = m_cand; m_edit = 0;
        compared++;
        if (user !== 2'(m_user) || editing !== 1'b0 || commit_cnt - c0 !== 1) begin
            mismatched++;
            $display("FAIL wrap_commit: got user=%0d edit=%0d commits=%0d want %0d/0/1",
                     user, editing, commit_cnt - c0, m_user);
        end
    endtask

    task automatic test_glitch_and_timeout;
        int c0;
        c0 = commit_cnt;
        key_next_n = 1'b0;
        tick(D - 1);
        key_next_n = 1'b1;
        tick(15);
        compared++;
        if (editing !== 1'b0 || candidate !== 2'(m_user)) begin
            mismatched++;
            $display("FAIL glitch: got edit=%0d cand=%0d want 0/%0d", editing, candidate, m_user);
        end
        key_next_n = 1'b0;
        tick(LAT);
        key_next_n = 1'b1;
        compared++;
        if (editing !== 1'b1 || candidate !== 2'((m_user + 1) % 4)) begin
            mismatched++;
            $display("FAIL timeout_enter: got edit=%0d cand=%0d want 1/%0d", editing, candidate, (m_user + 1) % 4);
        end
        tick(T - 1);
        compared++;
        if (editing !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_early: got edit=%0d want 1 one cycle before timeout", editing);
        end
        tick(1);
        compared++;
        if (editing !== 1'b0 || candidate !== 2'(m_user) || commit_cnt !== c0) begin
            mismatched++;
            $display("FAIL timeout_expire: got edit=%0d cand=%0d commits=%0d want 0/%0d/0",
                     editing, candidate, commit_cnt - c0, m_user);
        end
        tick(10);
    endtask

    task automatic test_simultaneous;
        int c0;
        press_next(8, 10);
        m_cand = (m_user + 1) % 4; m_edit = 1;
        if (m_cand != 2) begin
            press_next(8, 10);
            m_cand = (m_cand + 1) % 4;
        end
        c0 = commit_cnt;
        key_next_n = 1'b0;
        key_enter_n = 1'b0;
        tick(8);
        key_next_n = 1'b1;
        key_enter_n = 1'b1;
        tick(10);
        m_user = m_cand; m_edit = 0;
        compared++;
        if (user !== 2'(m_user) || candidate !== 2'(m_user) || editing !== 1'b0 || commit_cnt - c0 !== 1) begin
            mismatched++;
            $display("FAIL simultaneous: got user=%0d cand=%0d edit=%0d commits=%0d want %0d/%0d/0/1",
                     user, candidate, editing, commit_cnt - c0, m_user, m_user);
        end
    endtask

    task automatic test_hold_repeat;
        int c0;
        int base;
        int reps;
        int expect_c;
        c0 = commit_cnt;
        press_next(8, 10);
        base = (m_user + 1) % 4;
        key_next_n = 1'b0;
        tick(LAT);
        compared++;
        if (candidate !== 2'((base + 1) % 4)) begin
            mismatched++;
            $display("FAIL repeat_press: got cand=%0d want %0d", candidate, (base + 1) % 4);
        end
        for (int off = 1; off <= 19; off++) begin
            tick(1);
            if (off == 14) key_next_n = 1'b1;
            if (off == 9 || off == 10 || off == 13 || off == 16 || off == 19) begin
                reps = 0;
`ifdef USER_VALUE_AUTO_REPEAT_EN
                for (int t = H; t <= off; t += R) reps++;
`endif
                expect_c = (base + 1 + reps) % 4;
                compared++;
                if (candidate !== 2'(expect_c) || editing !== 1'b1) begin
                    mismatched++;
                    $display("FAIL repeat_off%0d: got cand=%0d edit=%0d want %0d/1", off, candidate, editing, expect_c);
                end
            end
        end
        tick(40);
        m_cand = m_user; m_edit = 0;
        compared++;
        if (editing !== 1'b0 || candidate !== 2'(m_user) || commit_cnt !== c0) begin
            mismatched++;
            $display("FAIL repeat_abandon: got edit=%0d cand=%0d commits=%0d want 0/%0d/0",
                     editing, candidate, commit_cnt - c0, m_user);
        end
    endtask

    task automatic test_random;
        int which;
        int low;
        int high;
        int exp_commits;
        int c0;
        c0 = commit_cnt;
        exp_commits = 0;
        for (int op = 0; op < 24; op++) begin
            which = $urandom_range(0, 1);
            low   = $urandom_range(D + 1, 8);
            high  = $urandom_range(8, 10);
            if (which == 0) begin
                press_next(low, high);
                m_cand = (m_edit != 0) ? (m_cand + 1) % 4 : (m_user + 1) % 4;
                m_edit = 1;
            end else begin
                press_enter(low, high);
                if (m_edit != 0) begin
                    m_user = m_cand;
                    m_edit = 0;
                    exp_commits++;
                end
            end
            compared++;
            if (user !== 2'(m_user) || candidate !== 2'(m_cand) || editing !== 1'(m_edit) ||
                commit_cnt - c0 !== exp_commits) begin
                mismatched++;
                $display("FAIL random_op%0d key=%0d: got user=%0d cand=%0d edit=%0d commits=%0d want %0d/%0d/%0d/%0d",
                         op, which, user, candidate, editing, commit_cnt - c0,
                         m_user, m_cand, m_edit, exp_commits);
            end
        end
    endtask

    task automatic test_reset_mid_edit;
        if (m_edit == 0) press_next(8, 10);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        m_user = 0; m_cand = 0; m_edit = 0;
        compared++;
        if (user !== 2'd0 || candidate !== 2'd0 || editing !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_edit: got user=%0d cand=%0d edit=%0d want 0/0/0", user, candidate, editing);
        end
    endtask

    initial begin
        test_reset;
        test_first_commit;
        test_wrap;
        test_glitch_and_timeout;
        test_simultaneous;
        test_hold_repeat;
        test_random;
        test_reset_mid_edit;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/user_value_entry.md
Name: user_value_entry

Overview:
- Input-side counterpart of the four-value display: produces the 2-bit `user` value that the display consumes.
- Turns two raw active-low board push-keys (NEXT, ENTER) into a debounced edit/commit sequence.
- Drives the committed value, the candidate being edited, and status flags.
- Sits between the board keys and the display top level.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a debounced key changes state (10 ms at 50 MHz); minimum 2.
- TIMEOUT_CYCLES, 250000000: idle cycles in EDIT before the edit is abandoned (5 s at 50 MHz).
- HOLD_CYCLES, 50000000: NEXT hold time before auto-repeat starts (AUTO_REPEAT_EN only).
- REPEAT_CYCLES, 12500000: auto-repeat period (AUTO_REPEAT_EN only).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- key_next_n  input  1  raw NEXT key, active-low, asynchronous to clk
- key_enter_n  input  1  raw ENTER key, active-low, asynchronous to clk
- user  output  2  committed value, 0..3
- candidate  output  2  value being edited; equals user outside EDIT
- editing  output  1  high while in EDIT
- commit  output  1  one-cycle pulse when user is updated

Behaviour:
- Reset (rst sampled high at posedge):
  - FSM goes to IDLE.
  - user=0, candidate=0, editing=0, commit=0.
  - Synchronizers are set to released (1); debounced states are set to released.
  - All counters are cleared.
  - Reset mid-edit discards the candidate.
- Input conditioning, per key:
  - 2-FF synchronizer.
  - Debounce counter counts consecutive cycles in which the synchronized level differs from the debounced state; it clears whenever they match.
  - On reaching DEBOUNCE_CYCLES the debounced state flips and the counter clears.
  - A press event is a one-cycle pulse on the released->pressed flip.
  - No event on release.
- Latency: a raw key held low from edge k gives a candidate/state update at edge k+DEBOUNCE_CYCLES+3. Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Key held through reset: the debouncer restarts released, so a press event occurs DEBOUNCE_CYCLES+2 cycles after reset deasserts.
- FSM states and transitions:
  - IDLE: editing=0, candidate=user.
    - NEXT event -> EDIT, with candidate=user+1 mod 4.
    - ENTER event is ignored.
  - EDIT: editing=1.
    - NEXT event -> candidate+1 mod 4 (3 wraps to 0).
    - ENTER event -> COMMIT, with user<=candidate.
    - Timeout counter clears on any event and increments otherwise. At TIMEOUT_CYCLES -> IDLE, candidate<=user, no commit.
    - NEXT and ENTER events in the same cycle: ENTER wins; the current candidate is committed without increment.
  - COMMIT: exactly one cycle.
    - commit=1, editing=0, user already holds the new value.
    - Events arriving in this cycle are dropped.
    - Next state is IDLE.
- Committing a value equal to the previous user value still pulses commit.
- All outputs are registered; no combinational path from the key inputs to the outputs.

Optional Feature:
- Macro: USER_VALUE_AUTO_REPEAT_EN.
- Defined:
  - While in EDIT with debounced NEXT held, after HOLD_CYCLES from the press event an internal repeat event increments candidate.
  - Further repeat events follow every REPEAT_CYCLES until NEXT is released.
  - Repeat events reset the timeout counter.
  - An ENTER event in the same cycle as a repeat event wins.
- Undefined: the hold/repeat counters and both parameters are unused; one increment per press only.

Decomposition:
- Shared package/header:
  - FSM state encodings: IDLE=2'd0, EDIT=2'd1, COMMIT=2'd2.
  - USER_VALUE_W=2.
  - Default cycle constants for the 50 MHz board clock.
- Sub-module `key_debounce`:
  - Parameter: DEBOUNCE_CYCLES.
  - Ports: clk, rst, key_n, pressed (debounced level), press (event pulse).
  - Instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20, HOLD_CYCLES=10, REPEAT_CYCLES=3):
- Reset, then idle 10 cycles -> user=0, candidate=0, editing=0, commit never high.
- NEXT held low 8 cycles, then ENTER held 8 cycles -> candidate=1 at edge 7 after NEXT falls, editing=1; one commit pulse; user=1; editing=0.
- Four NEXT presses then ENTER, from user=1 -> candidates 2,3,0,1 (wrap checked); commit with user=1.
- NEXT pulse low 3 cycles (below debounce) -> no state change; NEXT press then no activity for 20 cycles -> editing=0, candidate back to user, no commit.
- NEXT and ENTER fall in the same cycle while in EDIT at candidate=2 -> user=2, commit pulses once, no increment.
- With USER_VALUE_AUTO_REPEAT_EN defined, NEXT held 19 cycles after its press event in EDIT -> candidate increments at the press, then at +10, +13, +16, +19; without the macro, one increment only.
